// File: rtl/instr_fetch_stage.sv
// RV32I fetch stage: PC, one-outstanding imem req/gnt/rvalid fetch, IF/ID register and decode field split.
// Latency: id_* valid one cycle after imem_rvalid. Backpressure: no new request while IF/ID is full and not draining.
// Optional perf counters (fetch_count, stall_count) are present only when IFETCH_PERF_CNT_EN is defined.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  OP,
    output logic [2:0]  Funct3,
    output logic [6:0]  Funct7
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FULL,
        S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        load;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        load       = 1'b0;

        if (id_valid_q && id_ready) begin
            id_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_gnt) begin
                    state_d = branch_taken ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (branch_taken) begin
                        state_d = S_REQ;
                    end else begin
                        load    = 1'b1;
                        state_d = id_ready ? S_REQ : S_FULL;
                    end
                end else if (branch_taken) begin
                    state_d = S_DROP;
                end
            end
            S_FULL: begin
                if ((id_valid_q && id_ready) || branch_taken) begin
                    state_d = S_REQ;
                end
            end
            // The squashed response retires DROP even if a new redirect lands in the same cycle.
            S_DROP: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = pc_q;
            pc_d       = pc_q + 32'd4;
        end

        // A flush overrides both a load and a same-cycle decode handshake.
        if (branch_taken) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
            pc_d       = branch_target & ~32'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= (state_d == S_REQ);
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, stall_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            if (id_valid_q && id_ready && !branch_taken) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (id_valid_q && !id_ready) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign OP        = id_instr_q[6:0];
    assign Funct3    = id_instr_q[14:12];
    assign Funct7    = id_instr_q[31:25];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed vector table, reset corner cases, then random traffic vs a transaction model.
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gnt, rvalid, br, rdy;
    logic [31:0] rdata, tgt;

    logic        req_a, idv_a, req_b, idv_b;
    logic [31:0] addr_a, instr_a, pc_a, addr_b, instr_b, pc_b;
    logic [6:0]  op_a, f7_a, op_b, f7_b;
    logic [2:0]  f3_a, f3_b;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fc_a, sc_a, fc_b, sc_b;
`endif

    always #5 clk = ~clk;

    instr_fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req_a), .imem_addr(addr_a), .imem_gnt(gnt), .imem_rvalid(rvalid), .imem_rdata(rdata),
        .branch_taken(br), .branch_target(tgt), .id_ready(rdy),
        .id_valid(idv_a), .id_instr(instr_a), .id_pc(pc_a), .OP(op_a), .Funct3(f3_a), .Funct7(f7_a)
`ifdef IFETCH_PERF_CNT_EN
        , .fetch_count(fc_a), .stall_count(sc_a)
`endif
    );

    instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req_b), .imem_addr(addr_b), .imem_gnt(gnt), .imem_rvalid(rvalid), .imem_rdata(rdata),
        .branch_taken(br), .branch_target(tgt), .id_ready(rdy),
        .id_valid(idv_b), .id_instr(instr_b), .id_pc(pc_b), .OP(op_b), .Funct3(f3_b), .Funct7(f7_b)
`ifdef IFETCH_PERF_CNT_EN
        , .fetch_count(fc_b), .stall_count(sc_b)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_idv;
        logic        e_ci;
        logic [31:0] e_instr;
        logic [31:0] e_idpc;
        logic [31:0] e_fc, e_sc;
    } vec_t;

    function automatic vec_t v(logic g, logic r, logic [31:0] d, logic b, logic [31:0] t, logic y,
                               logic er, logic [31:0] ea, logic ev, logic ec, logic [31:0] ei,
                               logic [31:0] ep, logic [31:0] efc, logic [31:0] esc);
        vec_t x;
        x.gnt = g; x.rv = r; x.rdata = d; x.br = b; x.tgt = t; x.rdy = y;
        x.e_req = er; x.e_addr = ea; x.e_idv = ev; x.e_ci = ec; x.e_instr = ei;
        x.e_idpc = ep; x.e_fc = efc; x.e_sc = esc;
        return x;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_req"}, 32'(req_a), 32'd0);
        check({tag, "_addr"}, addr_a, 32'h0);
        check({tag, "_idv"}, 32'(idv_a), 32'd0);
        check({tag, "_instr"}, instr_a, NOP);
        check({tag, "_idpc"}, pc_a, 32'h0);
        check({tag, "_addr_wrapdut"}, addr_b, 32'hFFFF_FFFC);
        check({tag, "_idpc_wrapdut"}, pc_b, 32'hFFFF_FFFC);
`ifdef IFETCH_PERF_CNT_EN
        check({tag, "_fc"}, fc_a, 32'd0);
        check({tag, "_sc"}, sc_a, 32'd0);
`endif
    endtask

    // Transaction-level reference: outstanding fetches as a tagged queue, IF/ID as a slot.
    typedef struct {
        logic [31:0] addr;
        bit          squash;
    } fetch_t;
    fetch_t      q[$];
    bit          m_idle, m_want, m_v;
    logic [31:0] m_pc, m_instr, m_idpc, m_fc, m_sc;

    task automatic model_reset();
        q.delete();
        m_idle = 1; m_want = 0; m_v = 0;
        m_pc = 32'h0; m_instr = NOP; m_idpc = 32'h0; m_fc = 0; m_sc = 0;
    endtask

    task automatic model_step(input logic g, input logic r, input logic [31:0] d,
                              input logic b, input logic [31:0] t, input logic y);
        bit          had_v, accepted, popped, pop_sq, deliver, nw;
        logic [31:0] paddr;
        fetch_t      e;
        had_v = m_v; accepted = m_want && g;
        popped = 0; pop_sq = 0; deliver = 0; paddr = 32'h0;
        if (r && q.size() > 0) begin
            e = q.pop_front();
            popped = 1; pop_sq = e.squash || b; paddr = e.addr; deliver = !pop_sq;
        end
        if (b) foreach (q[k]) q[k].squash = 1;
        if (accepted) q.push_back('{addr: m_pc, squash: b});
        if (had_v && y && !b) m_fc = m_fc + 1;
        if (had_v && !y) m_sc = m_sc + 1;
        nw = 0;
        if (q.size() == 0)
            nw = m_idle || (m_want && !g) || b || (popped && pop_sq) || (deliver && y) || (!m_want && had_v && y);
        if (deliver) begin
            m_v = 1; m_instr = d; m_idpc = paddr; m_pc = paddr + 32'd4;
        end else if (had_v && y) begin
            m_v = 0;
        end
        if (b) begin
            m_v = 0; m_instr = NOP; m_pc = t & ~32'd3;
        end
        m_want = nw; m_idle = 0;
    endtask

    vec_t tbl[19];

    initial begin
        logic [31:0] i0, i1, i2, i3, junk, ex;
        bit          busy;
        int          cnt;
        i0 = 32'h00A0_0093; i1 = 32'h4020_8133; i2 = 32'h0020_A023; i3 = 32'h00C5_8663; junk = 32'hDEAD_BEEF;

        //          gnt rv rdata br tgt        rdy | req addr        idv ci instr idpc        fc sc
        tbl[0]  = v(0, 0, 0,    0, 0,          1,  0, 32'h0,     0, 1, NOP, 0,          0, 0);
        tbl[1]  = v(1, 0, 0,    0, 0,          1,  1, 32'h0,     0, 1, NOP, 0,          0, 0);
        tbl[2]  = v(0, 1, i0,   0, 0,          1,  0, 32'h0,     0, 1, NOP, 0,          0, 0);
        tbl[3]  = v(1, 0, 0,    0, 0,          1,  1, 32'h4,     1, 1, i0,  32'h0,      0, 0);
        tbl[4]  = v(0, 1, i1,   0, 0,          1,  0, 32'h4,     0, 0, 0,   0,          1, 0);
        tbl[5]  = v(1, 0, 0,    0, 0,          1,  1, 32'h8,     1, 1, i1,  32'h4,      1, 0);
        tbl[6]  = v(0, 1, i2,   0, 0,          0,  0, 32'h8,     0, 0, 0,   0,          2, 0);
        tbl[7]  = v(0, 0, 0,    0, 0,          0,  0, 32'hC,     1, 1, i2,  32'h8,      2, 0);
        tbl[8]  = v(0, 0, 0,    0, 0,          0,  0, 32'hC,     1, 1, i2,  32'h8,      2, 1);
        tbl[9]  = v(0, 0, 0,    0, 0,          0,  0, 32'hC,     1, 1, i2,  32'h8,      2, 2);
        tbl[10] = v(0, 0, 0,    0, 0,          1,  0, 32'hC,     1, 1, i2,  32'h8,      2, 3);
        tbl[11] = v(1, 0, 0,    0, 0,          1,  1, 32'hC,     0, 0, 0,   0,          3, 3);
        tbl[12] = v(0, 0, 0,    1, 32'h103,    1,  0, 32'hC,     0, 0, 0,   0,          3, 3);
        tbl[13] = v(0, 1, junk, 0, 0,          1,  0, 32'h100,   0, 1, NOP, 0,          3, 3);
        tbl[14] = v(1, 0, 0,    0, 0,          1,  1, 32'h100,   0, 1, NOP, 0,          3, 3);
        tbl[15] = v(0, 1, i3,   0, 0,          0,  0, 32'h100,   0, 1, NOP, 0,          3, 3);
        tbl[16] = v(0, 0, 0,    1, 32'h200,    1,  0, 32'h104,   1, 1, i3,  32'h100,    3, 3);
        tbl[17] = v(0, 0, 0,    0, 0,          1,  1, 32'h200,   0, 1, NOP, 0,          3, 3);
        tbl[18] = v(0, 0, 0,    0, 0,          1,  1, 32'h200,   0, 1, NOP, 0,          3, 3);

        rst_n = 0; gnt = 0; rvalid = 0; rdata = 0; br = 0; tgt = 0; rdy = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1;

        foreach (tbl[i]) begin
            gnt = tbl[i].gnt; rvalid = tbl[i].rv; rdata = tbl[i].rdata;
            br = tbl[i].br; tgt = tbl[i].tgt; rdy = tbl[i].rdy;
            check($sformatf("v%0d_req", i), 32'(req_a), 32'(tbl[i].e_req));
            check($sformatf("v%0d_addr", i), addr_a, tbl[i].e_addr);
            check($sformatf("v%0d_idv", i), 32'(idv_a), 32'(tbl[i].e_idv));
            ex = (i <= 12) ? tbl[i].e_addr - 32'd4 : tbl[i].e_addr;
            check($sformatf("v%0d_addr_wrapdut", i), addr_b, ex);
            if (tbl[i].e_ci) begin
                ex = tbl[i].e_instr;
                check($sformatf("v%0d_instr", i), instr_a, ex);
                check($sformatf("v%0d_op", i), 32'(op_a), 32'(ex[6:0]));
                check($sformatf("v%0d_f3", i), 32'(f3_a), 32'(ex[14:12]));
                check($sformatf("v%0d_f7", i), 32'(f7_a), 32'(ex[31:25]));
            end
            if (tbl[i].e_idv) begin
                check($sformatf("v%0d_idpc", i), pc_a, tbl[i].e_idpc);
                ex = (i <= 12) ? tbl[i].e_idpc - 32'd4 : tbl[i].e_idpc;
                check($sformatf("v%0d_idpc_wrapdut", i), pc_b, ex);
            end
`ifdef IFETCH_PERF_CNT_EN
            check($sformatf("v%0d_fc", i), fc_a, tbl[i].e_fc);
            check($sformatf("v%0d_sc", i), sc_a, tbl[i].e_sc);
`endif
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of WAIT, then a stale rvalid after release.
        gnt = 1; rvalid = 0; br = 0; rdy = 1;
        @(posedge clk);
        #1;
        gnt = 0;
        check("midwait_req", 32'(req_a), 32'd0);
        #3;
        rst_n = 0;
        #1;
        check_reset_values("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1; rvalid = 1; rdata = junk;
        check("late_rv_idle_req", 32'(req_a), 32'd0);
        @(posedge clk);
        #1;
        rvalid = 0;
        check("post_rst_req", 32'(req_a), 32'd1);
        check("post_rst_addr", addr_a, 32'h0);
        check("post_rst_idv", 32'(idv_a), 32'd0);
        check("post_rst_instr", instr_a, NOP);
        @(posedge clk);
        #1;
        check("post_rst_idv2", 32'(idv_a), 32'd0);
        check("post_rst_addr2", addr_a, 32'h0);

        // Random traffic against the reference model.
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        busy = 0; cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            rvalid = 0;
            if (busy) begin
                cnt--;
                if (cnt == 0) rvalid = 1;
            end
            rdata = $urandom;
            gnt = req_a && !busy && ($urandom_range(0, 1) == 1);
            br = ($urandom_range(0, 15) == 0);
            tgt = $urandom;
            rdy = ($urandom_range(0, 3) != 0);
            check("rnd_req", 32'(req_a), 32'(m_want));
            check("rnd_addr", addr_a, m_pc);
            check("rnd_idv", 32'(idv_a), 32'(m_v));
            check("rnd_instr", instr_a, m_instr);
            if (m_v) begin
                check("rnd_idpc", pc_a, m_idpc);
                check("rnd_op", 32'(op_a), 32'(m_instr[6:0]));
            end
`ifdef IFETCH_PERF_CNT_EN
            check("rnd_fc", fc_a, m_fc);
            check("rnd_sc", sc_a, m_sc);
`endif
            model_step(gnt, rvalid, rdata, br, tgt, rdy);
            if (rvalid) busy = 0;
            if (gnt) begin
                busy = 1;
                cnt = $urandom_range(1, 3);
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
